// File: rtl/axi_dw_r_packer.sv
// axi_dw_r_packer
//   Packs narrow AXI R beats into wide R beats (read-path upsizer).
//   A per-burst command gives the starting byte offset. The offset selects the
//   first narrow lane that is filled. A wide beat is emitted when the top lane
//   has been written or the narrow beat carries RLAST. Lanes that were never
//   written read as zero.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   cmd_*             burst command push (start offset within the wide word)
//   nr_*              narrow R channel (sink)
//   wr_*              wide R channel (source, registered)
module axi_dw_r_packer #(
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 64,
  parameter int unsigned IdWidth         = 4,
  parameter int unsigned UserWidth       = 1,
  parameter int unsigned CmdDepth        = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [$clog2(WideDataWidth/8)-1:0]   cmd_offset_i,
  input  logic                                 nr_valid_i,
  output logic                                 nr_ready_o,
  input  logic [NarrowDataWidth-1:0]           nr_data_i,
  input  logic [1:0]                           nr_resp_i,
  input  logic                                 nr_last_i,
  input  logic [IdWidth-1:0]                   nr_id_i,
  input  logic [UserWidth-1:0]                 nr_user_i,
  output logic                                 wr_valid_o,
  input  logic                                 wr_ready_i,
  output logic [WideDataWidth-1:0]             wr_data_o,
  output logic [1:0]                           wr_resp_o,
  output logic                                 wr_last_o,
  output logic [IdWidth-1:0]                   wr_id_o,
  output logic [UserWidth-1:0]                 wr_user_o
);

  localparam int unsigned Ratio = WideDataWidth / NarrowDataWidth;
  localparam int unsigned LaneW = $clog2(Ratio);
  localparam int unsigned OffW  = $clog2(WideDataWidth / 8);
  localparam int unsigned NbW   = $clog2(NarrowDataWidth / 8);
  localparam int unsigned PtrW  = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int unsigned CntW  = $clog2(CmdDepth + 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  // Command FIFO stores the start lane directly rather than the raw offset.
  logic [LaneW-1:0]         r_fifo [CmdDepth];
  logic [PtrW-1:0]          r_wptr;
  logic [PtrW-1:0]          r_rptr;
  logic [CntW-1:0]          r_count;

  state_t                   r_state;
  logic [LaneW-1:0]         r_lane;
  logic [WideDataWidth-1:0] r_acc;
  logic [1:0]               r_acc_resp;

  logic                     r_wvalid;
  logic [WideDataWidth-1:0] r_wdata;
  logic [1:0]               r_wresp;
  logic                     r_wlast;
  logic [IdWidth-1:0]       r_wid;
  logic [UserWidth-1:0]     r_wuser;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_completes;
  logic                     w_nr_hs;
  logic [WideDataWidth-1:0] w_merged;
  logic [1:0]               w_resp_merged;
  logic [LaneW-1:0]         w_push_lane;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CntW'(CmdDepth));
  assign cmd_ready_o = !w_full;
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_push_lane = cmd_offset_i[OffW-1:NbW];

  assign w_completes = (r_lane == LaneW'(Ratio - 1)) || nr_last_i;
  // A completing beat may only be taken if the output register is free or
  // draining in this same cycle.
  assign nr_ready_o  = (r_state == S_FILL) &&
                       (!w_completes || !r_wvalid || wr_ready_i);
  assign w_nr_hs     = nr_valid_i && nr_ready_o;
  assign w_pop       = w_nr_hs && nr_last_i;

  always_comb begin
    w_merged = r_acc;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (r_lane == LaneW'(i)) begin
        w_merged[i*NarrowDataWidth +: NarrowDataWidth] = nr_data_i;
      end
    end
  end

  // Resp encodings are already ordered by severity, so numeric max suffices.
  assign w_resp_merged = (nr_resp_i > r_acc_resp) ? nr_resp_i : r_acc_resp;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_push_lane;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrW'(CmdDepth - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(CmdDepth - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_acc      <= '0;
      r_acc_resp <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_lane     <= r_fifo[r_rptr];
            r_acc      <= '0;
            r_acc_resp <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_nr_hs) begin
            if (w_completes) begin
              r_acc      <= '0;
              r_acc_resp <= '0;
              r_lane     <= '0;
            end else begin
              r_acc      <= w_merged;
              r_acc_resp <= w_resp_merged;
              r_lane     <= r_lane + 1'b1;
            end
            if (nr_last_i) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_wresp  <= '0;
      r_wlast  <= 1'b0;
      r_wid    <= '0;
      r_wuser  <= '0;
    end else if (w_nr_hs && w_completes) begin
      r_wvalid <= 1'b1;
      r_wdata  <= w_merged;
      r_wresp  <= w_resp_merged;
      r_wlast  <= nr_last_i;
      r_wid    <= nr_id_i;
      r_wuser  <= nr_user_i;
    end else if (wr_ready_i) begin
      r_wvalid <= 1'b0;
    end
  end

  assign wr_valid_o = r_wvalid;
  assign wr_data_o  = r_wdata;
  assign wr_resp_o  = r_wresp;
  assign wr_last_o  = r_wlast;
  assign wr_id_o    = r_wid;
  assign wr_user_o  = r_wuser;

endmodule

// File: tb/tb_axi_dw_r_packer.sv
module tb_axi_dw_r_packer;

  localparam int unsigned NW = 32;
  localparam int unsigned WW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned UW = 1;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
  } wbeat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_offset = '0;
  logic          nr_valid = 1'b0;
  logic          nr_ready;
  logic [NW-1:0] nr_data = '0;
  logic [1:0]    nr_resp = '0;
  logic          nr_last = 1'b0;
  logic [IW-1:0] nr_id = '0;
  logic [UW-1:0] nr_user = '0;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [WW-1:0] wr_data;
  logic [1:0]    wr_resp;
  logic          wr_last;
  logic [IW-1:0] wr_id;
  logic [UW-1:0] wr_user;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  wbeat_t      exp_q[$];

  always #5 clk = ~clk;

  axi_dw_r_packer #(
    .NarrowDataWidth(NW),
    .WideDataWidth  (WW),
    .IdWidth        (IW),
    .UserWidth      (UW),
    .CmdDepth       (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_offset_i(cmd_offset),
    .nr_valid_i  (nr_valid),
    .nr_ready_o  (nr_ready),
    .nr_data_i   (nr_data),
    .nr_resp_i   (nr_resp),
    .nr_last_i   (nr_last),
    .nr_id_i     (nr_id),
    .nr_user_i   (nr_user),
    .wr_valid_o  (wr_valid),
    .wr_ready_i  (wr_ready),
    .wr_data_o   (wr_data),
    .wr_resp_o   (wr_resp),
    .wr_last_o   (wr_last),
    .wr_id_o     (wr_id),
    .wr_user_o   (wr_user)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Monitor: every accepted wide beat is checked against the scoreboard head.
  always begin
    @(negedge clk);
    if (rst_n && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wbeat: got data %h last %b, expected none", wr_data, wr_last);
      end else begin
        wbeat_t e;
        e = exp_q.pop_front();
        chk("wbeat", {8'h0, wr_data, wr_resp, wr_last, wr_id, wr_user}, {8'h0, e});
      end
    end
  end

  task automatic expect_w(input logic [WW-1:0] d, input logic [1:0] r, input logic l,
                          input logic [IW-1:0] id, input logic [UW-1:0] u);
    exp_q.push_back('{data: d, resp: r, last: l, id: id, user: u});
  endtask

  // All drivers start and end at posedge+1.
  task automatic push_cmd(input logic [2:0] off);
    int unsigned t = 0;
    logic rdy;
    cmd_valid  = 1'b1;
    cmd_offset = off;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) timeout_fail("cmd_push");
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [NW-1:0] d, input logic [1:0] r, input logic l,
                           input logic [IW-1:0] id, input logic [UW-1:0] u);
    int unsigned t = 0;
    logic rdy;
    nr_valid = 1'b1;
    nr_data  = d;
    nr_resp  = r;
    nr_last  = l;
    nr_id    = id;
    nr_user  = u;
    do begin
      @(negedge clk);
      rdy = nr_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) timeout_fail("nr_beat");
    nr_valid = 1'b0;
    nr_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] held;
    int unsigned t;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_valid", {79'h0, wr_valid}, 80'h0);
    chk("rst_wr_data", {16'h0, wr_data}, 80'h0);
    chk("rst_nr_ready", {79'h0, nr_ready}, 80'h0);
    chk("rst_cmd_ready", {79'h0, cmd_ready}, 80'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned four-beat burst
    expect_w(64'hBBBB_0002_AAAA_0001, 2'b00, 1'b0, 4'h3, 1'b1);
    expect_w(64'hDDDD_0004_CCCC_0003, 2'b00, 1'b1, 4'h3, 1'b1);
    push_cmd(3'h0);
    send_beat(32'hAAAA_0001, 2'b00, 1'b0, 4'h3, 1'b1);
    send_beat(32'hBBBB_0002, 2'b00, 1'b0, 4'h3, 1'b1);
    send_beat(32'hCCCC_0003, 2'b00, 1'b0, 4'h3, 1'b1);
    send_beat(32'hDDDD_0004, 2'b00, 1'b1, 4'h3, 1'b1);
    wait_drain();
    nr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("fifo_empty_nr_ready", {79'h0, nr_ready}, 80'h0);
    @(posedge clk);
    #1;
    nr_valid = 1'b0;

    // Offset 4: first beat lands in the upper lane and completes at once
    expect_w(64'h1111_0001_0000_0000, 2'b00, 1'b0, 4'h5, 1'b0);
    expect_w(64'h3333_0003_2222_0002, 2'b00, 1'b1, 4'h5, 1'b0);
    push_cmd(3'h4);
    send_beat(32'h1111_0001, 2'b00, 1'b0, 4'h5, 1'b0);
    send_beat(32'h2222_0002, 2'b00, 1'b0, 4'h5, 1'b0);
    send_beat(32'h3333_0003, 2'b00, 1'b1, 4'h5, 1'b0);
    wait_drain();

    // Single-beat burst
    expect_w(64'h0000_0000_5A5A_A5A5, 2'b00, 1'b1, 4'h1, 1'b0);
    push_cmd(3'h0);
    send_beat(32'h5A5A_A5A5, 2'b00, 1'b1, 4'h1, 1'b0);
    wait_drain();

    // Resp merge across pairs
    expect_w(64'h0000_0012_0000_0011, 2'b10, 1'b0, 4'h7, 1'b1);
    expect_w(64'h0000_0014_0000_0013, 2'b11, 1'b0, 4'h7, 1'b1);
    expect_w(64'h0000_0016_0000_0015, 2'b01, 1'b1, 4'h7, 1'b1);
    push_cmd(3'h0);
    send_beat(32'h11, 2'b00, 1'b0, 4'h7, 1'b1);
    send_beat(32'h12, 2'b10, 1'b0, 4'h7, 1'b1);
    send_beat(32'h13, 2'b10, 1'b0, 4'h7, 1'b1);
    send_beat(32'h14, 2'b11, 1'b0, 4'h7, 1'b1);
    send_beat(32'h15, 2'b00, 1'b0, 4'h7, 1'b1);
    send_beat(32'h16, 2'b01, 1'b1, 4'h7, 1'b1);
    wait_drain();

    // Backpressure on the wide side
    expect_w(64'hB0B0_B0B0_A0A0_A0A0, 2'b00, 1'b0, 4'h2, 1'b0);
    expect_w(64'hD0D0_D0D0_C0C0_C0C0, 2'b00, 1'b1, 4'h2, 1'b0);
    wr_ready = 1'b0;
    push_cmd(3'h0);
    fork
      begin
        send_beat(32'hA0A0_A0A0, 2'b00, 1'b0, 4'h2, 1'b0);
        send_beat(32'hB0B0_B0B0, 2'b00, 1'b0, 4'h2, 1'b0);
        send_beat(32'hC0C0_C0C0, 2'b00, 1'b0, 4'h2, 1'b0);
        send_beat(32'hD0D0_D0D0, 2'b00, 1'b1, 4'h2, 1'b0);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!wr_valid && t < 50);
        if (!wr_valid) timeout_fail("stall_first_wbeat");
        held = wr_data;
        chk("stall_first_data", {16'h0, held}, {16'h0, 64'hB0B0_B0B0_A0A0_A0A0});
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_valid_held", {79'h0, wr_valid}, 80'h1);
          chk("stall_data_held", {16'h0, wr_data}, {16'h0, held});
        end
        chk("stall_nr_ready_low", {78'h0, nr_valid, nr_ready}, 80'h2);
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_bubble_valid", {79'h0, wr_valid}, 80'h1);
        chk("no_bubble_data", {16'h0, wr_data}, {16'h0, 64'hD0D0_D0D0_C0C0_C0C0});
      end
    join
    wait_drain();

    // Fill the command FIFO, then reset in the middle of a burst
    push_cmd(3'h0);
    push_cmd(3'h0);
    push_cmd(3'h0);
    push_cmd(3'h0);
    @(negedge clk);
    chk("cmd_fifo_full", {79'h0, cmd_ready}, 80'h0);
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    send_beat(32'hDEAD_0001, 2'b00, 1'b0, 4'h9, 1'b0);
    send_beat(32'hDEAD_0002, 2'b00, 1'b0, 4'h9, 1'b0);
    chk("pre_reset_valid", {79'h0, wr_valid}, 80'h1);
    nr_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("reset_wr_valid", {79'h0, wr_valid}, 80'h0);
    chk("reset_nr_ready", {79'h0, nr_ready}, 80'h0);
    chk("reset_wr_data", {16'h0, wr_data}, 80'h0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", {79'h0, cmd_ready}, 80'h1);
    repeat (3) @(negedge clk);
    chk("post_reset_fifo_empty", {79'h0, nr_ready}, 80'h0);
    @(posedge clk);
    #1;
    nr_valid = 1'b0;

    // Normal operation after reset
    expect_w(64'h0000_0000_0BAD_F00D, 2'b00, 1'b1, 4'h4, 1'b1);
    push_cmd(3'h0);
    send_beat(32'h0BAD_F00D, 2'b00, 1'b1, 4'h4, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
